a5_1_cipher: RTL and testbench

Complete A5/1 stream-cipher engine: it drives the three majority-clocked LFSRs R1/R2/R3 through the key load, frame load and mixing phases, then XORs the keystream onto a serial bit stream. It sits between the serial data source and sink and performs both encryption and decryption, which are the same operation. The three registers are internal to this block and use the standard A5/1 feedback and shift semantics.

---
 rtl/a5_1_cipher.sv | 170 +++++++++++++++++
 tb/tb_a5_1_cipher.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a5_1_cipher.sv
// A5/1 stream cipher: key/frame load, majority-clocked mixing, then keystream XOR
// onto a ready/valid serial bit stream. Encryption and decryption are identical.
module a5_1_cipher #(
    parameter int KS_LEN  = 228,
    parameter int MIX_LEN = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [21:0] frame,
    output logic        busy,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic        out_valid,
    output logic        out_bit,
    input  logic        out_ready,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_FRAME,
        MIX,
        STREAM
    } state_t;

    localparam logic [9:0] KS_LAST  = 10'(KS_LEN - 1);
    localparam logic [7:0] MIX_LAST = 8'(MIX_LEN - 1);

    state_t state, state_next;

    logic [18:0] r1, r1_next, r1_maj;
    logic [21:0] r2, r2_next, r2_maj;
    logic [22:0] r3, r3_next, r3_maj;
    logic        fb1, fb2, fb3, maj, ks, load_bit, handshake, done_next;
    logic [63:0] key_sh;
    logic [21:0] frame_sh;
    logic [7:0]  phase_cnt, phase_cnt_next;
    logic [9:0]  bit_cnt, bit_cnt_next;

    assign fb1 = r1[13] ^ r1[16] ^ r1[17] ^ r1[18];
    assign fb2 = r2[20] ^ r2[21];
    assign fb3 = r3[7] ^ r3[20] ^ r3[21] ^ r3[22];
    assign maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);

    // A register steps in a majority clock only when its clock bit agrees with the vote
    assign r1_maj = (r1[8]  == maj) ? {r1[17:0], fb1} : r1;
    assign r2_maj = (r2[10] == maj) ? {r2[20:0], fb2} : r2;
    assign r3_maj = (r3[10] == maj) ? {r3[21:0], fb3} : r3;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == STREAM) && (!out_valid || out_ready);
    assign handshake = in_valid && in_ready;
    assign ks        = r1_next[18] ^ r2_next[21] ^ r3_next[22];

    always_comb begin
        state_next     = state;
        phase_cnt_next = phase_cnt;
        bit_cnt_next   = bit_cnt;
        r1_next        = r1;
        r2_next        = r2;
        r3_next        = r3;
        done_next      = 1'b0;
        load_bit       = 1'b0;
        case (state)
            IDLE: begin
                r1_next        = '0;
                r2_next        = '0;
                r3_next        = '0;
                phase_cnt_next = '0;
                bit_cnt_next   = '0;
                if (start) state_next = LOAD_KEY;
            end
            LOAD_KEY: begin
                load_bit = key_sh[phase_cnt[5:0]];
                r1_next  = {r1[17:0], fb1 ^ load_bit};
                r2_next  = {r2[20:0], fb2 ^ load_bit};
                r3_next  = {r3[21:0], fb3 ^ load_bit};
                if (phase_cnt == 8'd63) begin
                    phase_cnt_next = '0;
                    state_next     = LOAD_FRAME;
                end else begin
                    phase_cnt_next = phase_cnt + 8'd1;
                end
            end
            LOAD_FRAME: begin
                load_bit = frame_sh[phase_cnt[4:0]];
                r1_next  = {r1[17:0], fb1 ^ load_bit};
                r2_next  = {r2[20:0], fb2 ^ load_bit};
                r3_next  = {r3[21:0], fb3 ^ load_bit};
                if (phase_cnt == 8'd21) begin
                    phase_cnt_next = '0;
                    state_next     = MIX;
                end else begin
                    phase_cnt_next = phase_cnt + 8'd1;
                end
            end
            MIX: begin
                r1_next = r1_maj;
                r2_next = r2_maj;
                r3_next = r3_maj;
                if (phase_cnt == MIX_LAST) begin
                    phase_cnt_next = '0;
                    state_next     = STREAM;
                end else begin
                    phase_cnt_next = phase_cnt + 8'd1;
                end
            end
            STREAM: begin
                // Registers advance only on an accepted input bit, so a stalled source freezes them
                if (handshake) begin
                    r1_next = r1_maj;
                    r2_next = r2_maj;
                    r3_next = r3_maj;
                    if (bit_cnt == KS_LAST) begin
                        bit_cnt_next = '0;
                        done_next    = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + 10'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            done      <= 1'b0;
            key_sh    <= '0;
            frame_sh  <= '0;
        end else begin
            state     <= state_next;
            r1        <= r1_next;
            r2        <= r2_next;
            r3        <= r3_next;
            phase_cnt <= phase_cnt_next;
            bit_cnt   <= bit_cnt_next;
            done      <= done_next;
            if (state == IDLE && start) begin
                key_sh   <= key;
                frame_sh <= frame;
            end
        end
    end

    // Output holding register keeps draining independently of the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else if (handshake) begin
            out_valid <= 1'b1;
            out_bit   <= in_bit ^ ks;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_a5_1_cipher.sv
// Self-checking bench for a5_1_cipher: known-answer, round trip, backpressure,
// start timing, mid-stream reset, and a short KS_LEN=8/MIX_LEN=1 instance.
module tb_a5_1_cipher;

    localparam logic [63:0]  KAT_KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0]  KAT_FRAME = 22'h134;
    localparam logic [119:0] KAT_VEC   = 120'h534EAA582FE8151AB6E1855A728C00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;
    logic [63:0] key = '0;
    logic [21:0] frame = '0;
    logic        busy, in_ready, out_valid, out_bit, done;

    logic        start8 = 1'b0, in_valid8 = 1'b0, in_bit8 = 1'b0, out_ready8 = 1'b0;
    logic [63:0] key8 = '0;
    logic [21:0] frame8 = '0;
    logic        busy8, in_ready8, out_valid8, out_bit8, done8;

    int tests = 0;
    int failures = 0;

    bit data_in[1024];
    bit data_out[1024];
    bit pt[1024];
    bit ct[1024];
    bit ks_ref[1024];
    int n_out;
    int done_cnt;

    // Reference model: registers as plain bit arrays, taps as masks
    bit          m_reg[3][23];
    int          m_len[3]  = '{19, 22, 23};
    int          m_clk[3]  = '{8, 10, 10};
    int unsigned m_taps[3] = '{32'h072000, 32'h300000, 32'h700080};

    always #5 clk = ~clk;

    a5_1_cipher dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .frame(frame), .busy(busy),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .out_valid(out_valid),
        .out_bit(out_bit), .out_ready(out_ready), .done(done)
    );

    a5_1_cipher #(.KS_LEN(8), .MIX_LEN(1)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .key(key8), .frame(frame8), .busy(busy8),
        .in_valid(in_valid8), .in_bit(in_bit8), .in_ready(in_ready8), .out_valid(out_valid8),
        .out_bit(out_bit8), .out_ready(out_ready8), .done(done8)
    );

    function automatic void m_step(input logic [2:0] en, input bit inj);
        bit fbv;
        for (int r = 0; r < 3; r++) begin
            if (en[r]) begin
                fbv = inj;
                for (int k = 0; k < m_len[r]; k++)
                    if (m_taps[r][k]) fbv ^= m_reg[r][k];
                for (int k = m_len[r] - 1; k > 0; k--) m_reg[r][k] = m_reg[r][k-1];
                m_reg[r][0] = fbv;
            end
        end
    endfunction

    function automatic void m_majority();
        int ones = 0;
        logic [2:0] en;
        for (int r = 0; r < 3; r++) ones += int'(m_reg[r][m_clk[r]]);
        for (int r = 0; r < 3; r++) en[r] = (m_reg[r][m_clk[r]] == (ones >= 2));
        m_step(en, 1'b0);
    endfunction

    function automatic void model_gen(input logic [63:0] k, input logic [21:0] f,
                                      input int mix, input int n);
        for (int r = 0; r < 3; r++)
            for (int b = 0; b < 23; b++) m_reg[r][b] = 1'b0;
        for (int i = 0; i < 64; i++) m_step(3'b111, k[i]);
        for (int i = 0; i < 22; i++) m_step(3'b111, f[i]);
        for (int i = 0; i < mix; i++) m_majority();
        for (int i = 0; i < n; i++) begin
            m_majority();
            ks_ref[i] = m_reg[0][18] ^ m_reg[1][21] ^ m_reg[2][22];
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic doStart(input logic [63:0] k, input logic [21:0] f);
        key = k;
        frame = f;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key = {$urandom, $urandom};
        frame = 22'($urandom);
    endtask

    task automatic waitReady(output int cyc);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 1;
        #1;
        while (!in_ready && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Feeds data_in[0..nbits-1], collects emitted bits into data_out, counts done pulses
    task automatic applyStimulus(input int nbits, input bit gaps, input bit bp);
        int  sent = 0;
        int  cyc = 0;
        bit  hs_in, hs_out;
        n_out = 0;
        done_cnt = 0;
        while (n_out < nbits && cyc < 5000) begin
            in_valid = (sent < nbits) && (!gaps || ($urandom_range(0, 3) != 0));
            in_bit = data_in[sent];
            out_ready = !bp || ($urandom_range(0, 1) == 1);
            #1;
            if (done) done_cnt++;
            if (out_valid && !out_ready) checkOutput("in_ready_backpressure", in_ready, 0);
            hs_in = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                data_out[n_out] = out_bit;
                n_out++;
            end
            @(posedge clk); #1;
            if (hs_in) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream_bits_out", n_out, nbits);
        for (int i = 0; i < 3; i++) begin
            #1;
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int cyc;
        int busy_bad;
        logic [15:0] first16;
        bit d8[8];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_bit", out_bit, 0);
        checkOutput("reset_done", done, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_busy", busy, 0);

        // Start timing with an ignored second start at cycle 50
        doStart(KAT_KEY, KAT_FRAME);
        in_valid = 1'b0;
        out_ready = 1'b1;
        busy_bad = 0;
        cyc = 1;
        #1;
        while (!in_ready && cyc < 400) begin
            if (!busy) busy_bad++;
            if (cyc == 50) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        checkOutput("busy_during_setup", busy_bad, 0);
        checkOutput("in_ready_first_cycle", cyc, 187);

        // Known-answer vector, all-zero plaintext
        model_gen(KAT_KEY, KAT_FRAME, 100, 228);
        for (int i = 0; i < 228; i++) data_in[i] = 1'b0;
        applyStimulus(228, 1'b0, 1'b0);
        first16 = '0;
        for (int i = 0; i < 16; i++) first16[15-i] = data_out[i];
        checkOutput("kat_first16", first16, 16'h534E);
        for (int i = 0; i < 114; i++) checkOutput("kat_vector_bit", data_out[i], KAT_VEC[119-i]);
        for (int i = 0; i < 228; i++) checkOutput("kat_model_bit", data_out[i], ks_ref[i]);
        checkOutput("kat_done_pulses", done_cnt, 1);
        checkOutput("kat_busy_after", busy, 0);

        // Backpressure and input gaps on the same vector
        doStart(KAT_KEY, KAT_FRAME);
        waitReady(cyc);
        checkOutput("bp_in_ready_cycle", cyc, 187);
        applyStimulus(228, 1'b1, 1'b1);
        for (int i = 0; i < 228; i++) checkOutput("bp_model_bit", data_out[i], ks_ref[i]);
        checkOutput("bp_done_pulses", done_cnt, 1);

        // Round trip with random key, frame and data
        key8 = {$urandom, $urandom};
        frame8 = 22'($urandom);
        model_gen(key8, frame8, 100, 228);
        for (int i = 0; i < 228; i++) begin
            pt[i] = 1'($urandom_range(0, 1));
            data_in[i] = pt[i];
        end
        doStart(key8, frame8);
        waitReady(cyc);
        applyStimulus(228, 1'b1, 1'b0);
        checkOutput("rt_enc_done_pulses", done_cnt, 1);
        for (int i = 0; i < 228; i++) begin
            ct[i] = data_out[i];
            checkOutput("rt_cipher_bit", ct[i], pt[i] ^ ks_ref[i]);
            data_in[i] = ct[i];
        end
        doStart(key8, frame8);
        waitReady(cyc);
        applyStimulus(228, 1'b0, 1'b1);
        checkOutput("rt_dec_done_pulses", done_cnt, 1);
        for (int i = 0; i < 228; i++) checkOutput("rt_plain_bit", data_out[i], pt[i]);

        // Reset in the middle of STREAM after 100 bits, with one bit pending
        model_gen(KAT_KEY, KAT_FRAME, 100, 228);
        for (int i = 0; i < 228; i++) data_in[i] = 1'b0;
        doStart(KAT_KEY, KAT_FRAME);
        waitReady(cyc);
        applyStimulus(100, 1'b0, 1'b0);
        checkOutput("mid_busy_before_reset", busy, 1);
        in_valid = 1'b1;
        in_bit = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        checkOutput("mid_pending_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_busy", busy, 0);
        checkOutput("mid_reset_in_ready", in_ready, 0);
        checkOutput("mid_reset_out_valid", out_valid, 0);
        checkOutput("mid_reset_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        doStart(KAT_KEY, KAT_FRAME);
        waitReady(cyc);
        checkOutput("post_reset_ready_cycle", cyc, 187);
        applyStimulus(228, 1'b0, 1'b0);
        first16 = '0;
        for (int i = 0; i < 16; i++) first16[15-i] = data_out[i];
        checkOutput("post_reset_first16", first16, 16'h534E);
        checkOutput("post_reset_done_pulses", done_cnt, 1);

        // Short build: KS_LEN=8, MIX_LEN=1
        key8 = {$urandom, $urandom};
        frame8 = 22'($urandom);
        model_gen(key8, frame8, 1, 8);
        for (int i = 0; i < 8; i++) d8[i] = 1'($urandom_range(0, 1));
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        key8 = ~key8;
        out_ready8 = 1'b1;
        cyc = 1;
        #1;
        while (!in_ready8 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("short_in_ready_cycle", cyc, 88);
        for (int i = 0; i < 8; i++) begin
            in_bit8 = d8[i];
            in_valid8 = 1'b1;
            #1;
            checkOutput("short_done_early", done8, 0);
            if (i > 0) checkOutput("short_out_bit", out_bit8, d8[i-1] ^ ks_ref[i-1]);
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0;
        #1;
        checkOutput("short_done_pulse", done8, 1);
        checkOutput("short_busy_fall", busy8, 0);
        checkOutput("short_last_valid", out_valid8, 1);
        checkOutput("short_last_bit", out_bit8, d8[7] ^ ks_ref[7]);
        @(posedge clk); #1;
        checkOutput("short_done_single", done8, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
